// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer for the shared 32-bit ALU: grants one of two
// requesters, drives the ALU for its registered latency, and holds the response.
//
// state   | meaning
// IDLE    | ALU idle (NOP), ready offered to the arbitration winner
// ISSUE   | latched operands/op on the ALU inputs, ALU captures next edge
// CAPTURE | latched values still driven, ALU result sampled next edge
// RESP    | response held until in_resp_ready
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_req0_valid,
  output logic        out_req0_ready,
  input  logic [31:0] in_req0_a,
  input  logic [31:0] in_req0_b,
  input  logic [2:0]  in_req0_op,
  input  logic        in_req1_valid,
  output logic        out_req1_ready,
  input  logic [31:0] in_req1_a,
  input  logic [31:0] in_req1_b,
  input  logic [2:0]  in_req1_op,
  output logic [31:0] out_alu_a,
  output logic [31:0] out_alu_b,
  output logic [2:0]  out_alu_op,
  input  logic [31:0] in_alu_result,
  input  logic        in_alu_zero,
  input  logic        in_alu_neg,
  output logic        out_resp_valid,
  input  logic        in_resp_ready,
  output logic        out_resp_id,
  output logic [31:0] out_resp_result,
  output logic        out_resp_zero,
  output logic        out_resp_neg,
  output logic        out_resp_err
);

  localparam logic [2:0] OP_NOP = 3'b011;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [31:0] resp_result_q, resp_result_d;
  logic        resp_zero_q, resp_zero_d;
  logic        resp_neg_q, resp_neg_d;
  logic        resp_err_q, resp_err_d;

  logic        idle;
  logic        grant0, grant1, accept;
  logic [31:0] sel_a, sel_b;
  logic [2:0]  sel_op;
  logic        sel_illegal;

  // last_q names the requester granted most recently; the other one wins a tie.
  // Gating with rst_n keeps both readys low while reset is held.
  always_comb begin
    idle        = (state_q == IDLE);
    grant0      = rst_n & idle & in_req0_valid & (~in_req1_valid | last_q);
    grant1      = rst_n & idle & in_req1_valid & (~in_req0_valid | ~last_q);
    accept      = grant0 | grant1;
    sel_a       = grant1 ? in_req1_a  : in_req0_a;
    sel_b       = grant1 ? in_req1_b  : in_req0_b;
    sel_op      = grant1 ? in_req1_op : in_req0_op;
    sel_illegal = (sel_op == 3'b101) || (sel_op == 3'b110);
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    resp_neg_d    = resp_neg_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_d    = grant1;
          resp_id_d = grant1;
          if (sel_illegal) begin
            state_d       = RESP;
            resp_valid_d  = 1'b1;
            resp_result_d = 32'd0;
            resp_zero_d   = 1'b0;
            resp_neg_d    = 1'b0;
            resp_err_d    = 1'b1;
          end else begin
            state_d = ISSUE;
            a_d     = sel_a;
            b_d     = sel_b;
            op_d    = sel_op;
          end
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        state_d       = RESP;
        resp_valid_d  = 1'b1;
        resp_result_d = in_alu_result;
        resp_zero_d   = in_alu_zero;
        resp_neg_d    = in_alu_neg;
        resp_err_d    = 1'b0;
      end
      RESP: begin
        if (in_resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      op_q          <= OP_NOP;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= 32'd0;
      resp_zero_q   <= 1'b0;
      resp_neg_q    <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
      resp_neg_q    <= resp_neg_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign out_req0_ready  = grant0;
  assign out_req1_ready  = grant1;
  assign out_alu_a       = a_q;
  assign out_alu_b       = b_q;
  assign out_alu_op      = ((state_q == ISSUE) || (state_q == CAPTURE)) ? op_q : OP_NOP;
  assign out_resp_valid  = resp_valid_q;
  assign out_resp_id     = resp_id_q;
  assign out_resp_result = resp_result_q;
  assign out_resp_zero   = resp_zero_q;
  assign out_resp_neg    = resp_neg_q;
  assign out_resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: registered ALU stand-in, transaction-level model checked
// every negedge, plus directed scenarios with hand-computed literal expectations.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_req0_valid = 1'b0, in_req1_valid = 1'b0;
  logic        out_req0_ready, out_req1_ready;
  logic [31:0] in_req0_a = '0, in_req0_b = '0, in_req1_a = '0, in_req1_b = '0;
  logic [2:0]  in_req0_op = 3'b011, in_req1_op = 3'b011;
  logic [31:0] out_alu_a, out_alu_b;
  logic [2:0]  out_alu_op;
  logic [31:0] in_alu_result;
  logic        in_alu_zero, in_alu_neg;
  logic        out_resp_valid;
  logic        in_resp_ready = 1'b1;
  logic        out_resp_id;
  logic [31:0] out_resp_result;
  logic        out_resp_zero, out_resp_neg, out_resp_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .in_req0_valid(in_req0_valid), .out_req0_ready(out_req0_ready),
    .in_req0_a(in_req0_a), .in_req0_b(in_req0_b), .in_req0_op(in_req0_op),
    .in_req1_valid(in_req1_valid), .out_req1_ready(out_req1_ready),
    .in_req1_a(in_req1_a), .in_req1_b(in_req1_b), .in_req1_op(in_req1_op),
    .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_alu_op(out_alu_op),
    .in_alu_result(in_alu_result), .in_alu_zero(in_alu_zero), .in_alu_neg(in_alu_neg),
    .out_resp_valid(out_resp_valid), .in_resp_ready(in_resp_ready),
    .out_resp_id(out_resp_id), .out_resp_result(out_resp_result),
    .out_resp_zero(out_resp_zero), .out_resp_neg(out_resp_neg), .out_resp_err(out_resp_err)
  );

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] prev);
    case (op)
      3'b100:  return a + b;
      3'b010:  return a + 32'd1;
      3'b001:  return -a;
      3'b000:  return b - a;
      3'b111:  return a;
      default: return prev;
    endcase
  endfunction

  // ALU stand-in: registered, never reset, NOP holds the previous result
  logic [31:0] alu_res = '0;
  always @(posedge clk) alu_res <= alu_f(out_alu_op, out_alu_a, out_alu_b, alu_res);
  assign in_alu_result = alu_res;
  assign in_alu_zero   = (alu_res == 32'd0);
  assign in_alu_neg    = alu_res[31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: outstanding job, cycles until response, expected payload
  bit          m_busy = 0, m_last = 1, m_id = 0, m_legal = 1;
  int          m_cnt = 0;
  logic [2:0]  m_op = 3'b011;
  logic [31:0] m_a = '0, m_b = '0, m_alu = '0, e_res = '0;
  bit          e_zero = 0, e_neg = 0, e_err = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0;
      m_last = 1;
    end else if (m_busy) begin
      if (m_cnt == 2) begin
        m_alu = alu_f(m_op, m_a, m_b, m_alu);
        m_cnt = 1;
      end else if (m_cnt == 1) begin
        e_res  = m_alu;
        e_zero = (m_alu == 32'd0);
        e_neg  = m_alu[31];
        e_err  = 0;
        m_cnt  = 0;
      end else if (in_resp_ready) begin
        m_busy = 0;
      end
    end else if (in_req0_valid || in_req1_valid) begin
      m_id    = (in_req0_valid && in_req1_valid) ? !m_last : in_req1_valid;
      m_last  = m_id;
      m_busy  = 1;
      m_op    = m_id ? in_req1_op : in_req0_op;
      m_a     = m_id ? in_req1_a : in_req0_a;
      m_b     = m_id ? in_req1_b : in_req0_b;
      m_legal = !(m_op == 3'b101 || m_op == 3'b110);
      if (m_legal) m_cnt = 2;
      else begin
        m_cnt = 0; e_res = '0; e_zero = 0; e_neg = 0; e_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit er0, er1, erv, eact;
    er0  = rst_n && !m_busy && in_req0_valid && (!in_req1_valid || m_last);
    er1  = rst_n && !m_busy && in_req1_valid && (!in_req0_valid || !m_last);
    erv  = rst_n && m_busy && (m_cnt == 0);
    eact = rst_n && m_busy && (m_cnt > 0);
    chk("m_ready0", out_req0_ready, er0);
    chk("m_ready1", out_req1_ready, er1);
    chk("m_resp_valid", out_resp_valid, erv);
    if (erv) begin
      chk("m_resp_id", out_resp_id, m_id);
      chk("m_resp_result", out_resp_result, e_res);
      chk("m_resp_zero", out_resp_zero, e_zero);
      chk("m_resp_neg", out_resp_neg, e_neg);
      chk("m_resp_err", out_resp_err, e_err);
    end
    if (!rst_n || !m_busy || eact || !m_legal)
      chk("m_alu_op", out_alu_op, eact ? m_op : 3'b011);
    if (eact) begin
      chk("m_alu_a", out_alu_a, m_a);
      chk("m_alu_b", out_alu_b, m_b);
    end
    if (!rst_n) begin
      chk("m_rst_alu_a", out_alu_a, 32'd0);
      chk("m_rst_alu_b", out_alu_b, 32'd0);
      chk("m_rst_resp_result", out_resp_result, 32'd0);
      chk("m_rst_resp_id", out_resp_id, 1'b0);
      chk("m_rst_resp_flags", {out_resp_zero, out_resp_neg, out_resp_err}, 3'b000);
    end
  end

  task automatic set_req(input int id, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      in_req0_valid = v; in_req0_op = op; in_req0_a = a; in_req0_b = b;
    end else begin
      in_req1_valid = v; in_req1_op = op; in_req1_a = a; in_req1_b = b;
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic wait_accept(input int id, input string name);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if ((id == 0) ? out_req0_ready : out_req1_ready) done = 1;
    end
    chk(name, done, 1'b1);
    @(posedge clk);
    #1;
    if (id == 0) in_req0_valid = 1'b0;
    else in_req1_valid = 1'b0;
  endtask

  // Returns on the negedge where the response is visible.
  task automatic wait_resp(input string name);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_resp_valid) got = 1;
    end
    chk(name, got, 1'b1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset: readys low even with both valids up
    set_req(0, 1'b1, 3'b100, 32'd1, 32'd1);
    set_req(1, 1'b1, 3'b100, 32'd1, 32'd1);
    @(negedge clk);
    chk("rst_ready0", out_req0_ready, 1'b0);
    chk("rst_ready1", out_req1_ready, 1'b0);
    chk("rst_alu_op", out_alu_op, 3'b011);
    chk("rst_resp_valid", out_resp_valid, 1'b0);
    next_cycle();
    in_req0_valid = 1'b0;
    in_req1_valid = 1'b0;
    next_cycle();
    rst_n = 1'b1;

    // 5 + 7
    set_req(0, 1'b1, 3'b100, 32'd5, 32'd7);
    @(negedge clk);
    chk("t1_ready0", out_req0_ready, 1'b1);
    next_cycle();
    in_req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_alu_op", out_alu_op, 3'b100);
    chk("t1_alu_a", out_alu_a, 32'd5);
    chk("t1_alu_b", out_alu_b, 32'd7);
    @(negedge clk);
    chk("t1_not_yet", out_resp_valid, 1'b0);
    @(negedge clk);
    chk("t1_valid", out_resp_valid, 1'b1);
    chk("t1_id", out_resp_id, 1'b0);
    chk("t1_result", out_resp_result, 32'd12);
    chk("t1_flags", {out_resp_zero, out_resp_neg, out_resp_err}, 3'b000);
    next_cycle();

    // tie after reset: req0, then req1, then req0 again
    do_reset();
    set_req(0, 1'b1, 3'b000, 32'd3, 32'd3);
    set_req(1, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'd0);
    @(negedge clk);
    chk("t2_tie_ready0", out_req0_ready, 1'b1);
    chk("t2_tie_ready1", out_req1_ready, 1'b0);
    next_cycle();
    in_req0_valid = 1'b0;
    wait_resp("t2_resp0_seen");
    chk("t2_r0_id", out_resp_id, 1'b0);
    chk("t2_r0_result", out_resp_result, 32'd0);
    chk("t2_r0_zero", out_resp_zero, 1'b1);
    next_cycle();
    wait_accept(1, "t2_acc1");
    wait_resp("t2_resp1_seen");
    chk("t2_r1_id", out_resp_id, 1'b1);
    chk("t2_r1_result", out_resp_result, 32'd0);
    chk("t2_r1_zero", out_resp_zero, 1'b1);
    next_cycle();
    set_req(0, 1'b1, 3'b100, 32'd1, 32'd1);
    set_req(1, 1'b1, 3'b100, 32'd2, 32'd2);
    @(negedge clk);
    chk("t2_tie3_ready0", out_req0_ready, 1'b1);
    chk("t2_tie3_ready1", out_req1_ready, 1'b0);
    next_cycle();
    in_req0_valid = 1'b0;
    wait_resp("t2_resp2_seen");
    chk("t2_r2_result", out_resp_result, 32'd2);
    next_cycle();
    wait_accept(1, "t2_acc3");
    wait_resp("t2_resp3_seen");
    chk("t2_r3_result", out_resp_result, 32'd4);
    chk("t2_r3_id", out_resp_id, 1'b1);
    next_cycle();

    // illegal opcode
    set_req(1, 1'b1, 3'b110, 32'd7, 32'd7);
    wait_accept(1, "t3_acc");
    @(negedge clk);
    chk("t3_valid", out_resp_valid, 1'b1);
    chk("t3_err", out_resp_err, 1'b1);
    chk("t3_result", out_resp_result, 32'd0);
    chk("t3_id", out_resp_id, 1'b1);
    chk("t3_alu_op", out_alu_op, 3'b011);
    next_cycle();

    // response back-pressure
    in_resp_ready = 1'b0;
    set_req(0, 1'b1, 3'b100, 32'd1, 32'd2);
    wait_accept(0, "t4_acc");
    set_req(0, 1'b1, 3'b010, 32'd9, 32'd0);
    wait_resp("t4_resp_seen");
    chk("t4_result", out_resp_result, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", out_resp_valid, 1'b1);
      chk("t4_hold_result", out_resp_result, 32'd3);
      chk("t4_hold_ready0", out_req0_ready, 1'b0);
    end
    next_cycle();
    in_resp_ready = 1'b1;
    @(negedge clk);
    chk("t4_hs_ready0", out_req0_ready, 1'b0);
    @(negedge clk);
    chk("t4_after_ready0", out_req0_ready, 1'b1);
    next_cycle();
    in_req0_valid = 1'b0;
    wait_resp("t4_resp2_seen");
    chk("t4_result2", out_resp_result, 32'd10);
    next_cycle();

    // pass-through then NOP returns the held ALU result
    set_req(0, 1'b1, 3'b111, 32'h8000_0000, 32'd0);
    wait_accept(0, "t5_acc_pass");
    wait_resp("t5_resp_pass");
    chk("t5_pass_result", out_resp_result, 32'h8000_0000);
    chk("t5_pass_flags", {out_resp_zero, out_resp_neg}, 2'b01);
    next_cycle();
    set_req(0, 1'b1, 3'b011, 32'd5, 32'd5);
    wait_accept(0, "t5_acc_nop");
    wait_resp("t5_resp_nop");
    chk("t5_nop_result", out_resp_result, 32'h8000_0000);
    chk("t5_nop_flags", {out_resp_zero, out_resp_neg, out_resp_err}, 3'b010);
    next_cycle();

    // reset during CAPTURE
    set_req(0, 1'b1, 3'b100, 32'd1, 32'd1);
    wait_accept(0, "t6_acc");
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_alu_op", out_alu_op, 3'b011);
    chk("t6_rst_valid", out_resp_valid, 1'b0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    set_req(1, 1'b1, 3'b100, 32'd2, 32'd3);
    @(negedge clk);
    chk("t6_ready1", out_req1_ready, 1'b1);
    chk("t6_valid_after", out_resp_valid, 1'b0);
    next_cycle();
    in_req1_valid = 1'b0;
    wait_resp("t6_resp_seen");
    chk("t6_result", out_resp_result, 32'd5);
    chk("t6_id", out_resp_id, 1'b1);
    next_cycle();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU. Accepts operations from two clients over valid/ready handshakes, grants round-robin, drives the ALU's operand and opcode inputs, and accounts for the ALU's registered one-cycle latency. Captures result and flags into a held response register. Sits between the fetch/PC-update path (requester 0) and the execute path (requester 1) and the single ALU instance.

## Interface
- No parameters; data width fixed at 32, opcode width fixed at 3.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_req0_valid / in_req1_valid  in  1  request pending from requester 0 / 1
- out_req0_ready / out_req1_ready  out  1  request accepted this cycle
- in_req0_a, in_req0_b / in_req1_a, in_req1_b  in  32  operands
- in_req0_op / in_req1_op  in  3  ALU opcode
- out_alu_a, out_alu_b  out  32  to ALU in_a / in_b
- out_alu_op  out  3  to ALU in_ctrl_aluop
- in_alu_result  in  32  from ALU out_result
- in_alu_zero, in_alu_neg  in  1  from ALU flags
- out_resp_valid  out  1  response held
- in_resp_ready  in  1  response consumed
- out_resp_id  out  1  requester that owns the response
- out_resp_result  out  32  captured result
- out_resp_zero, out_resp_neg  out  1  captured flags
- out_resp_err  out  1  illegal opcode

## Operation
- Opcodes: 100 a+b, 010 a+1, 001 -a, 000 b-a, 111 pass a, 011 NOP. 101 and 110 are illegal.
- FSM states:
  - IDLE: out_alu_op=011. Ready is asserted to the grant winner only.
  - ISSUE: drives latched a/b/op. The ALU captures on the next edge.
  - CAPTURE: still drives the latched values. Result and flags are sampled on the next edge.
  - RESP: out_resp_valid=1 and the response is held stable.
- Transitions:
  - IDLE→ISSUE on accept of a legal op.
  - IDLE→RESP on accept of an illegal op. Response is err=1, result=0, zero=0, neg=0, and no ALU issue.
  - ISSUE→CAPTURE unconditionally.
  - CAPTURE→RESP unconditionally, with err=0.
  - RESP→IDLE on in_resp_ready=1.
- Arbitration:
  - Round-robin with a last-grant pointer that updates on each accept.
  - With both valid, the requester not last granted wins. A lone valid wins regardless.
  - out_reqN_ready is combinational from state, both valids and the pointer. It is never high for both requesters, and never high outside IDLE.
  - Accept = valid & ready at a rising edge. Operands and op are latched at accept.
  - Requesters hold valid and payload stable until accepted.
- Requester NOP (011) is legal. It is issued and returns the ALU's held result and flags unchanged.
- out_resp_id is the id of the accepted requester.
- All arithmetic is performed by the ALU. This block does no width conversion.

## Timing
- Reset values:
  - state=IDLE, pointer=1 (requester 0 wins the first tie).
  - out_alu_a=0, out_alu_b=0, out_alu_op=011.
  - out_resp_valid=0, out_resp_id=0, out_resp_result=0, out_resp_zero=0, out_resp_neg=0, out_resp_err=0.
  - Both readys are 0 while rst_n=0.
- Legal op, accept at edge E0:
  - out_alu_* valid after E0.
  - ALU updates at E1. Response registers load at E2.
  - out_resp_valid=1 after E2, so latency is 2 cycles from accept.
- Illegal op: out_resp_valid=1 after E0+1 edge.
- Minimum spacing between accepts is 4 cycles for legal ops, with in_resp_ready held high.
- Response fields do not change while out_resp_valid=1.
- A new request arriving during ISSUE, CAPTURE or RESP waits. Its ready stays 0.
- The response handshake and a new accept never occur on the same edge. The accept happens at the earliest one cycle after RESP exits.
- Reset mid-operation: in-flight work is dropped and no response is produced. Outputs return to their reset values immediately. The ALU itself is not reset by this block.

## Test plan
- Reset, then req0 op=100 a=5 b=7 -> ready0 in the accept cycle; out_alu_op=100 after accept; resp after 2 more edges: id=0, result=12, zero=0, neg=0, err=0.
- Both valid in the same cycle: req0 op=000 a=3 b=3, req1 op=010 a=0xFFFFFFFF -> req0 granted first (resp result=0, zero=1). req1 is granted only after that response is consumed (result=0, zero=1). A third tie goes to req0.
- req1 op=110 -> response one edge after accept: err=1, result=0, id=1; out_alu_op stays 011 throughout.
- Hold in_resp_ready=0 for 5 cycles after response valid -> response fields are constant; both readys stay 0; in_req0_valid=1 is accepted only after the resp handshake.
- req0 op=111 a=0x80000000, then req0 op=011 -> second response returns result=0x80000000 with the same flags as the first.
- Drop rst_n during CAPTURE -> out_resp_valid stays 0, out_alu_op=011 immediately; after release, req1 alone is granted on first request.
